// File: rtl/xc_malu_pkg.sv
// Shared definitions for the XCrypto multi-cycle ALU issue sequencer:
// op codes, uop bit positions, FSM states and the op decode helper.
package xc_malu_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [4:0] OP_DIV      = 5'd0;
  localparam logic [4:0] OP_DIVU     = 5'd1;
  localparam logic [4:0] OP_REM      = 5'd2;
  localparam logic [4:0] OP_REMU     = 5'd3;
  localparam logic [4:0] OP_MUL      = 5'd4;
  localparam logic [4:0] OP_MULH     = 5'd5;
  localparam logic [4:0] OP_MULHU    = 5'd6;
  localparam logic [4:0] OP_MULHSU   = 5'd7;
  localparam logic [4:0] OP_CLMUL    = 5'd8;
  localparam logic [4:0] OP_CLMULH   = 5'd9;
  localparam logic [4:0] OP_PMUL_L   = 5'd10;
  localparam logic [4:0] OP_PMUL_H   = 5'd11;
  localparam logic [4:0] OP_PCLMUL_L = 5'd12;
  localparam logic [4:0] OP_PCLMUL_H = 5'd13;
  localparam logic [4:0] OP_MADD     = 5'd14;
  localparam logic [4:0] OP_MSUB     = 5'd15;
  localparam logic [4:0] OP_MACC     = 5'd16;
  localparam logic [4:0] OP_MMUL     = 5'd17;

  localparam int UOP_W      = 14;
  localparam int UOP_DIV    = 0;
  localparam int UOP_DIVU   = 1;
  localparam int UOP_REM    = 2;
  localparam int UOP_REMU   = 3;
  localparam int UOP_MUL    = 4;
  localparam int UOP_MULU   = 5;
  localparam int UOP_MULSU  = 6;
  localparam int UOP_CLMUL  = 7;
  localparam int UOP_PMUL   = 8;
  localparam int UOP_PCLMUL = 9;
  localparam int UOP_MADD   = 10;
  localparam int UOP_MSUB   = 11;
  localparam int UOP_MACC   = 12;
  localparam int UOP_MMUL   = 13;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    SEL_LO   = 2'd0,
    SEL_HI   = 2'd1,
    SEL_PAIR = 2'd2
  } sel_t;

  typedef struct packed {
    logic             valid;
    logic [UOP_W-1:0] uop;
    sel_t             sel;
  } op_dec_t;

  // Undefined codes decode to valid=0 and an all-zero uop.
  function automatic op_dec_t decode_op(input logic [4:0] op);
    op_dec_t d;
    d.valid = 1'b1;
    d.uop   = '0;
    d.sel   = SEL_LO;
    case (op)
      OP_DIV:      d.uop[UOP_DIV] = 1'b1;
      OP_DIVU:     d.uop[UOP_DIVU] = 1'b1;
      OP_REM:      d.uop[UOP_REM] = 1'b1;
      OP_REMU:     d.uop[UOP_REMU] = 1'b1;
      OP_MUL:      d.uop[UOP_MUL] = 1'b1;
      OP_MULH:     begin d.uop[UOP_MUL] = 1'b1;    d.sel = SEL_HI;   end
      OP_MULHU:    begin d.uop[UOP_MULU] = 1'b1;   d.sel = SEL_HI;   end
      OP_MULHSU:   begin d.uop[UOP_MULSU] = 1'b1;  d.sel = SEL_HI;   end
      OP_CLMUL:    d.uop[UOP_CLMUL] = 1'b1;
      OP_CLMULH:   begin d.uop[UOP_CLMUL] = 1'b1;  d.sel = SEL_HI;   end
      OP_PMUL_L:   d.uop[UOP_PMUL] = 1'b1;
      OP_PMUL_H:   begin d.uop[UOP_PMUL] = 1'b1;   d.sel = SEL_HI;   end
      OP_PCLMUL_L: d.uop[UOP_PCLMUL] = 1'b1;
      OP_PCLMUL_H: begin d.uop[UOP_PCLMUL] = 1'b1; d.sel = SEL_HI;   end
      OP_MADD:     begin d.uop[UOP_MADD] = 1'b1;   d.sel = SEL_PAIR; end
      OP_MSUB:     begin d.uop[UOP_MSUB] = 1'b1;   d.sel = SEL_PAIR; end
      OP_MACC:     begin d.uop[UOP_MACC] = 1'b1;   d.sel = SEL_PAIR; end
      OP_MMUL:     begin d.uop[UOP_MMUL] = 1'b1;   d.sel = SEL_PAIR; end
      default:     d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/xc_malu_lfsr.sv
// 32-bit right-shifting Galois LFSR, advances every clock; holds SEED in reset.
module xc_malu_lfsr
  import xc_malu_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_1234
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [31:0] value
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value <= SEED;
    end else begin
      value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_TAPS : 32'h0);
    end
  end

endmodule

// File: rtl/xc_malu_issue.sv
// Issue/response sequencer in front of the XCrypto multi-cycle ALU: one op in
// flight, registered operands and response, LFSR-masked flush between ops.
//
// state | meaning
// FLUSH | ALU flushed with LFSR mask data (one cycle, also the reset state)
// IDLE  | waiting for a request, req_ready = !kill
// RUN   | ALU inputs valid, waiting for malu_ready or timeout
// RESP  | registered response held until rsp_ready
module xc_malu_issue
  import xc_malu_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 63,
  parameter bit          FLUSH_RANDOM = 1'b1,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_1234
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_pw,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic        kill,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_data_hi,
  output logic        rsp_wide,
  output logic        rsp_err,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic        malu_valid,
  output logic        malu_flush,
  output logic [31:0] malu_flush_data,
  input  logic [63:0] malu_result,
  input  logic        malu_ready
);

  localparam logic [5:0] TMO_LOAD = 6'(TIMEOUT);

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  op_q;
  logic [5:0]  tmo_q;
  logic [31:0] lfsr_value;
  op_dec_t     dec;
  logic        accept;
  logic        run_done;
  logic        tmo_hit;

  xc_malu_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .value  (lfsr_value)
  );

  assign dec      = decode_op(op_q);
  assign tmo_hit  = (tmo_q == 6'd0);
  assign accept   = (state_q == ST_IDLE) && req_valid && !kill;
  // Undefined ops finish after one RUN cycle without ever presenting to the ALU.
  assign run_done = (state_q == ST_RUN) && !kill && (!dec.valid || malu_ready || tmo_hit);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSH: state_d = ST_IDLE;
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (kill) begin
          state_d = ST_FLUSH;
        end else if (run_done) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:  if (kill || rsp_ready) state_d = ST_FLUSH;
      default:  state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    malu_valid      = 1'b0;
    malu_uop        = '0;
    malu_flush      = 1'b0;
    malu_flush_data = '0;
    case (state_q)
      ST_FLUSH: begin
        malu_flush      = 1'b1;
        malu_flush_data = FLUSH_RANDOM ? lfsr_value : 32'h0;
      end
      ST_IDLE:  req_ready = !kill;
      ST_RUN: begin
        malu_valid = dec.valid;
        malu_uop   = dec.uop;
      end
      ST_RESP:  rsp_valid = 1'b1;
      default:  malu_flush = 1'b1;
    endcase
  end

  // Timeout is a down-counter loaded on accept; zero is the terminal count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_q        <= '0;
      tmo_q       <= '0;
      malu_rs1    <= '0;
      malu_rs2    <= '0;
      malu_rs3    <= '0;
      malu_pw     <= '0;
      rsp_data    <= '0;
      rsp_data_hi <= '0;
      rsp_wide    <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= req_op;
        malu_rs1 <= req_rs1;
        malu_rs2 <= req_rs2;
        malu_rs3 <= req_rs3;
        malu_pw  <= req_pw;
        tmo_q    <= TMO_LOAD;
      end else if ((state_q == ST_RUN) && !tmo_hit) begin
        tmo_q <= tmo_q - 6'd1;
      end

      if (run_done) begin
        if (dec.valid && malu_ready) begin
          rsp_err     <= 1'b0;
          rsp_wide    <= (dec.sel == SEL_PAIR);
          rsp_data    <= (dec.sel == SEL_HI) ? malu_result[63:32] : malu_result[31:0];
          rsp_data_hi <= (dec.sel == SEL_PAIR) ? malu_result[63:32] : 32'h0;
        end else begin
          rsp_err     <= 1'b1;
          rsp_wide    <= 1'b0;
          rsp_data    <= 32'h0;
          rsp_data_hi <= 32'h0;
        end
      end
    end
  end

endmodule
